rt_tender: RTL and testbench



---
 rtl/rt_tender.sv | 171 +++++++++++++++++
 tb/tb_rt_tender.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_tender.sv
// Self-running runtime requantization tile: scans an on-chip tensor for channel and global
// abs maxima, assigns each channel a power-of-two group, and writes the rescaled channels to VPU memory.
module rt_tender #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int NEL = 4,
  parameter int GW  = 2,
  parameter logic [NCH*NEL*DW-1:0] INIT = {
    8'd2,  8'd4,  8'hFF, 8'd3,
    8'd1,  8'hE7, 8'd2,  8'd6,
    8'd7,  8'd3,  8'hCE, 8'd12,
    8'd64, 8'd5,  8'hEC, 8'd100
  }
) (
  input logic clk,
  input logic rstn
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NG = 2**GW;
  localparam int XW = DW + NG - 1;
  localparam logic signed [XW-1:0] SMAX = XW'(2**(DW-1) - 1);
  localparam logic signed [XW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {IDLE, MAX, GROUP, QUANT, DONE} state_t;

  state_t                state;
  logic [NCH*NEL*DW-1:0] Tensors;
  logic [DW-1:0]         max_val;
  logic [NCH*GW-1:0]     grp_idx;
  logic [CW-1:0]         ch;
  logic [DW-1:0]         chmax [NCH];

  logic [DW-1:0]         elem [NCH][NEL];
  logic [DW-1:0]         cur_max;
  logic [NCH*GW-1:0]     grp_next;
  logic [NEL*DW-1:0]     qword;
  logic                  we;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++)
      for (int unsigned e = 0; e < NEL; e++)
        elem[c][e] = Tensors[(c*NEL+e)*DW +: DW];
  end

  // |x| as DW-bit unsigned, so the most negative value maps to 2^(DW-1)
  always_comb begin
    logic [DW-1:0] a;
    cur_max = '0;
    a       = '0;
    for (int unsigned e = 0; e < NEL; e++) begin
      a = elem[ch][e][DW-1] ? ('0 - elem[ch][e]) : elem[ch][e];
      if (a > cur_max) cur_max = a;
    end
  end

  always_comb begin
    logic [GW-1:0] g;
    logic          found;
    grp_next = '0;
    g        = '0;
    found    = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      g     = GW'(NG-1);
      found = 1'b0;
      for (int unsigned k = 0; k < NG-1; k++) begin
        if (!found && (chmax[c] > (max_val >> (k+1)))) begin
          g     = GW'(k);
          found = 1'b1;
        end
      end
      if (max_val == '0) g = '0;
      grp_next[c*GW +: GW] = g;
    end
  end

  always_comb begin
    logic [GW-1:0]          g_cur;
    logic signed [XW-1:0]   wide;
    qword = '0;
    g_cur = grp_idx[ch*GW +: GW];
    wide  = '0;
    for (int unsigned e = 0; e < NEL; e++) begin
      wide = XW'(signed'(elem[ch][e]));
      wide = wide <<< g_cur;
      if (wide > SMAX)      qword[e*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
      else if (wide < SMIN) qword[e*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
      else                  qword[e*DW +: DW] = wide[DW-1:0];
    end
  end

  assign we = (state == QUANT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      Tensors <= INIT;
      max_val <= '0;
      grp_idx <= '0;
      ch      <= '0;
      for (int unsigned c = 0; c < NCH; c++) chmax[c] <= '0;
    end else begin
      case (state)
        IDLE: state <= MAX;
        MAX: begin
          chmax[ch] <= cur_max;
          if (cur_max > max_val) max_val <= cur_max;
          if (ch == CW'(NCH-1)) begin
            ch    <= '0;
            state <= GROUP;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        GROUP: begin
          grp_idx <= grp_next;
          state   <= QUANT;
        end
        QUANT: begin
          if (ch == CW'(NCH-1)) begin
            ch    <= '0;
            state <= DONE;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  rt_tender_vpu #(
    .NCH(NCH),
    .WW (NEL*DW),
    .AW (CW)
  ) VPU_memory (
    .clk  (clk),
    .rstn (rstn),
    .we   (we),
    .waddr(ch),
    .wdata(qword)
  );

endmodule

// VPU result memory: one word per channel, cleared asynchronously on reset.
module rt_tender_vpu #(
  parameter int NCH = 4,
  parameter int WW  = 32,
  parameter int AW  = 2
) (
  input logic          clk,
  input logic          rstn,
  input logic          we,
  input logic [AW-1:0] waddr,
  input logic [WW-1:0] wdata
);

  logic [WW-1:0] vpu_memory [0:NCH-1];

  // Writes of an unchanged word are suppressed; stored contents are identical either way
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) vpu_memory[i] <= '0;
    end else if (we && (vpu_memory[waddr] != wdata)) begin
      vpu_memory[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_rt_tender.sv
// Bench for rt_tender: several tiles with different initial tensors, checked per edge and at rest
// against a plain-arithmetic model, including randomly timed mid-run resets.
module tb_rt_tender;

  localparam int ND = 5;

  logic clk;
  logic rstn;

  int vectors;
  int miscompares;

  logic [7:0]   obs_max [ND];
  logic [7:0]   obs_grp [ND];
  logic [127:0] obs_ten [ND];
  logic [31:0]  obs_mem [ND][4];

  int           exp_chm [ND][4];
  int           exp_max [ND];
  logic [7:0]   exp_grp [ND];
  logic [31:0]  exp_mem [ND][4];

  function automatic logic [127:0] tens_of(input int d);
    logic [127:0] t;
    t = '0;
    case (d)
      0: t = {8'd2, 8'd4, 8'hFF, 8'd3,  8'd1, 8'hE7, 8'd2, 8'd6,
              8'd7, 8'd3, 8'hCE, 8'd12, 8'd64, 8'd5, 8'hEC, 8'd100};
      1: t[(2*4+1)*8 +: 8] = 8'h80;
      3: t = {8'd0, 8'd7, 8'hE0, 8'd32, 8'd1, 8'd19, 8'hEC, 8'd20,
              8'd5, 8'd12, 8'hF0, 8'd16, 8'd0, 8'd0, 8'd0, 8'h80};
      4: t = {8'd0, 8'd0, 8'd0, 8'd1,   8'd0, 8'd9, 8'd0, 8'h9C,
              8'd0, 8'd0, 8'hEC, 8'd20, 8'd0, 8'd0, 8'd0, 8'd100};
      default: t = '0;
    endcase
    return t;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    rt_tender #(
      .DW  (8),
      .NCH (4),
      .NEL (4),
      .GW  (2),
      .INIT(tens_of(d))
    ) u (
      .clk (clk),
      .rstn(rstn)
    );
    assign obs_max[d] = u.max_val;
    assign obs_grp[d] = u.grp_idx;
    assign obs_ten[d] = u.Tensors;
    for (genvar c = 0; c < 4; c++) begin : g_w
      assign obs_mem[d][c] = u.VPU_memory.vpu_memory[c];
    end
  end

  // Reference: group is the smallest g whose doubled-up channel max still exceeds the global max
  task automatic build_model();
    logic [127:0]      t;
    logic signed [7:0] b;
    int v, a, g, q;
    for (int d = 0; d < ND; d++) begin
      t = tens_of(d);
      exp_max[d] = 0;
      for (int c = 0; c < 4; c++) begin
        exp_chm[d][c] = 0;
        for (int e = 0; e < 4; e++) begin
          b = t[(c*4+e)*8 +: 8];
          v = int'(b);
          a = (v < 0) ? -v : v;
          if (a > exp_chm[d][c]) exp_chm[d][c] = a;
        end
        if (exp_chm[d][c] > exp_max[d]) exp_max[d] = exp_chm[d][c];
      end
      exp_grp[d] = '0;
      for (int c = 0; c < 4; c++) begin
        g = 0;
        if (exp_max[d] != 0)
          while (g < 3 && exp_chm[d][c] * (2 << g) <= exp_max[d]) g++;
        exp_grp[d][c*2 +: 2] = 2'(g);
        exp_mem[d][c] = '0;
        for (int e = 0; e < 4; e++) begin
          b = t[(c*4+e)*8 +: 8];
          q = int'(b) * (1 << g);
          if (q > 127) q = 127;
          if (q < -128) q = -128;
          exp_mem[d][c][e*8 +: 8] = 8'(q);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #10;
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (obs_max[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_max d%0d got %h exp 00", d, obs_max[d]);
      end
      vectors++;
      if (obs_grp[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_grp d%0d got %h exp 00", d, obs_grp[d]);
      end
      vectors++;
      if (obs_ten[d] !== tens_of(d)) begin
        miscompares++;
        $display("FAIL reset_tensor d%0d got %h exp %h", d, obs_ten[d], tens_of(d));
      end
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (obs_mem[d][c] !== 32'h0) begin
          miscompares++;
          $display("FAIL reset_mem d%0d w%0d got %h exp 0", d, c, obs_mem[d][c]);
        end
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_timeline(input int last_edge);
    int        emax;
    logic [7:0]  eg;
    logic [31:0] ew;
    for (int n = 1; n <= last_edge; n++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        emax = 0;
        for (int c = 0; c < 4; c++)
          if (c <= n - 2 && exp_chm[d][c] > emax) emax = exp_chm[d][c];
        vectors++;
        if (obs_max[d] !== 8'(emax)) begin
          miscompares++;
          $display("FAIL edge_max d%0d edge%0d got %0d exp %0d", d, n, obs_max[d], emax);
        end
        eg = (n >= 6) ? exp_grp[d] : 8'h00;
        vectors++;
        if (obs_grp[d] !== eg) begin
          miscompares++;
          $display("FAIL edge_grp d%0d edge%0d got %h exp %h", d, n, obs_grp[d], eg);
        end
        for (int c = 0; c < 4; c++) begin
          ew = (n >= 7 + c) ? exp_mem[d][c] : 32'h0;
          vectors++;
          if (obs_mem[d][c] !== ew) begin
            miscompares++;
            $display("FAIL edge_mem d%0d w%0d edge%0d got %h exp %h", d, c, n, obs_mem[d][c], ew);
          end
        end
      end
    end
  endtask

  task automatic test_final();
    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (obs_max[d] !== 8'(exp_max[d])) begin
        miscompares++;
        $display("FAIL final_max d%0d got %0d exp %0d", d, obs_max[d], exp_max[d]);
      end
      vectors++;
      if (obs_grp[d] !== exp_grp[d]) begin
        miscompares++;
        $display("FAIL final_grp d%0d got %h exp %h", d, obs_grp[d], exp_grp[d]);
      end
      vectors++;
      if (obs_ten[d] !== tens_of(d)) begin
        miscompares++;
        $display("FAIL final_tensor d%0d got %h exp %h", d, obs_ten[d], tens_of(d));
      end
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (obs_mem[d][c] !== exp_mem[d][c]) begin
          miscompares++;
          $display("FAIL final_mem d%0d w%0d got %h exp %h", d, c, obs_mem[d][c], exp_mem[d][c]);
        end
      end
    end
    vectors++;
    if ({obs_max[0], obs_grp[0]} !== {8'd100, 8'hE4}) begin
      miscompares++;
      $display("FAIL default_max_grp got %h exp 64e4", {obs_max[0], obs_grp[0]});
    end
    vectors++;
    if ({obs_mem[0][0], obs_mem[0][1], obs_mem[0][2], obs_mem[0][3]}
        !== {32'h4005EC64, 32'h0E069C18, 32'h049C0818, 32'h1020F818}) begin
      miscompares++;
      $display("FAIL default_mem got %h %h %h %h", obs_mem[0][0], obs_mem[0][1],
               obs_mem[0][2], obs_mem[0][3]);
    end
  endtask

  task automatic test_abort(input int k);
    @(negedge clk);
    rstn = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rstn = 1'b1;
    test_timeline(k);
    #2;
    rstn = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if ({obs_max[d], obs_grp[d]} !== 16'h0) begin
        miscompares++;
        $display("FAIL abort_clear d%0d edge%0d got %h exp 0", d, k, {obs_max[d], obs_grp[d]});
      end
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (obs_mem[d][c] !== 32'h0) begin
          miscompares++;
          $display("FAIL abort_mem d%0d w%0d edge%0d got %h exp 0", d, c, k, obs_mem[d][c]);
        end
      end
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rstn = 1'b1;
    test_timeline(12);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    build_model();
    test_reset();
    release_reset();
    test_timeline(12);
    test_final();
    test_abort(8);
    test_final();
    for (int i = 0; i < 4; i++) begin
      test_abort(int'($urandom_range(1, 11)));
      test_final();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
